// File: rtl/retire_trace_buffer_pkg.sv
// Shared definitions for the retirement trace buffer: state encoding,
// fixed field widths and the packed entry width helper.
package retire_trace_buffer_pkg;

    typedef enum logic {
        TRACE_CAPTURE = 1'b0,
        TRACE_FROZEN  = 1'b1
    } trace_state_e;

    localparam int INST_W  = 32;
    localparam int WADDR_W = 5;
    localparam int CYCLE_W = 32;

    // Entry layout, MSB first: pc, inst, wen, waddr, wdata, cycle
    function automatic int entry_width(input int pc_w, input int data_w);
        return pc_w + INST_W + 1 + WADDR_W + data_w + CYCLE_W;
    endfunction

endpackage

// File: rtl/retire_trace_buffer_mem.sv
// Trace storage: DEPTH x WIDTH array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module retire_trace_buffer_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store one packed entry per accepted capture
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace recorder: captures retired instructions into a circular
// buffer, freezes on halt/freeze/no-wrap fill, then drains oldest-first.
module retire_trace_buffer
    import retire_trace_buffer_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,
    parameter int WRAP      = 1,
    parameter int FILTER_WB = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     retire_valid,
    input  logic [PC_W-1:0]          retire_pc,
    input  logic [INST_W-1:0]        retire_inst,
    input  logic                     retire_wen,
    input  logic [WADDR_W-1:0]       retire_waddr,
    input  logic [DATA_W-1:0]        retire_wdata,
    input  logic                     halt_sig,
    input  logic                     freeze_req,
    input  logic                     rearm,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [PC_W-1:0]          rd_pc,
    output logic [INST_W-1:0]        rd_inst,
    output logic                     rd_wen,
    output logic [WADDR_W-1:0]       rd_waddr,
    output logic [DATA_W-1:0]        rd_wdata,
    output logic [CYCLE_W-1:0]       rd_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     frozen,
    output logic [CYCLE_W-1:0]       cycle_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_width(PC_W, DATA_W);

    trace_state_e  state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          capture;
    logic          full;
    logic          write_en;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    // Decode capture/pop qualifiers and the read-side handshake
    always_comb begin
        full     = (count == CW'(DEPTH));
        capture  = (state == TRACE_CAPTURE) && retire_valid
                   && ((FILTER_WB == 0) || retire_wen);
        write_en = capture && (!full || (WRAP != 0));
        rd_valid = (state == TRACE_FROZEN) && (count != '0);
        pop      = rd_valid && rd_ready;
    end

    assign wr_entry = {retire_pc, retire_inst, retire_wen, retire_waddr,
                       retire_wdata, cycle_count};
    assign {rd_pc, rd_inst, rd_wen, rd_waddr, rd_wdata, rd_cycle} = rd_entry;
    assign frozen = (state == TRACE_FROZEN);

    retire_trace_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (write_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    // Capture/freeze FSM together with pointers, occupancy and flags
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= TRACE_CAPTURE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (state == TRACE_CAPTURE) begin
                if (capture) begin
                    if (!full) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count + 1'b1;
                    end else if (WRAP != 0) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        rd_ptr   <= rd_ptr + 1'b1;
                        overflow <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                if (halt_sig || freeze_req || (capture && full && (WRAP == 0))) begin
                    state <= TRACE_FROZEN;
                end
            end else begin
                if (rearm) begin
                    state    <= TRACE_CAPTURE;
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    count    <= '0;
                    overflow <= 1'b0;
                end else if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
            end
        end
    end

endmodule
